// File: rtl/i2c_host.sv
// i2c_host: single-master I2C byte engine; START/STOP take 4*CLKDIV+1 cycles, WRITE/READ 36*CLKDIV+1.
// One command at a time (cmd_ready only in IDLE); CLOCK_STRETCH_EN enables target SCL stretching.
module i2c_host #(
  parameter int CLKDIV = 125
) (
  input  logic       clk,
  input  logic       res,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_last,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       ack_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam int DW = $clog2(CLKDIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_XFER, S_FINISH} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] div;
  logic [1:0]    q;
  logic [3:0]    bit_cnt;
  logic [1:0]    cmd_r;
  logic          last_r;
  logic [7:0]    sh;
  logic          ack_smp;
  logic          sda_hold;
  logic          rd_flag;
  logic [1:0]    sda_sync;
  logic          accept, active, hold, tick, cell_end;

  assign accept   = cmd_valid && cmd_ready;
  assign active   = (state == S_START) || (state == S_STOP) || (state == S_XFER);
  assign tick     = active && !hold && (div == DW'(CLKDIV - 1));
  assign cell_end = tick && (q == 2'd3);

`ifdef CLOCK_STRETCH_EN
  logic [1:0] scl_sync;
  logic [1:0] settle;
  // settle masks the sync-pipeline delay after our own SCL release so only a real stretch holds
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      scl_sync <= 2'b11;
      settle   <= 2'd0;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      if (state == S_XFER && q[1]) begin
        if (settle != 2'd2) settle <= settle + 2'd1;
      end else begin
        settle <= 2'd0;
      end
    end
  end
  assign hold = (state == S_XFER) && q[1] && (settle == 2'd2) && !scl_sync[1];
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold       = 1'b0;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_START: state_nxt = S_START;
            CMD_STOP:  state_nxt = busy ? S_STOP : S_FINISH;
            default:   state_nxt = busy ? S_XFER : S_FINISH;
          endcase
        end
      end
      S_START, S_STOP: if (cell_end) state_nxt = S_FINISH;
      S_XFER:          if (cell_end && bit_cnt == 4'd8) state_nxt = S_FINISH;
      default:         state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    done      = (state == S_FINISH);
    rd_valid  = (state == S_FINISH) && rd_flag;
    // between commands SCL stays low while the bus is owned, SDA keeps its last level
    scl_oe    = busy;
    sda_oe    = sda_hold;
    case (state)
      S_START: begin
        scl_oe = (q == 2'd0) ? busy : (q == 2'd3);
        sda_oe = q[1];
      end
      S_STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = !q[1];
      end
      S_XFER: begin
        scl_oe = !q[1];
        if (bit_cnt == 4'd8) sda_oe = (cmd_r == CMD_READ) && !last_r;
        else                 sda_oe = (cmd_r == CMD_WRITE) && !sh[7];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      div      <= '0;
      q        <= 2'd0;
      bit_cnt  <= 4'd0;
      cmd_r    <= 2'd0;
      last_r   <= 1'b0;
      sh       <= 8'd0;
      ack_smp  <= 1'b0;
      sda_hold <= 1'b0;
      rd_flag  <= 1'b0;
      busy     <= 1'b0;
      ack_err  <= 1'b0;
      rd_data  <= 8'd0;
      sda_sync <= 2'b11;
    end else begin
      sda_sync <= {sda_sync[0], sda_in};
      if (!active) begin
        div     <= '0;
        q       <= 2'd0;
        bit_cnt <= 4'd0;
      end else begin
        if (hold || tick) div <= '0;
        else              div <= div + 1'b1;
        if (tick)     q       <= q + 2'd1;
        if (cell_end) bit_cnt <= bit_cnt + 4'd1;
        sda_hold <= sda_oe;
      end
      if (accept) begin
        cmd_r  <= cmd;
        last_r <= cmd_last;
        sh     <= cmd_data;
      end
      // receive samples on the tick ending q2; transmit shifts at the end of each cell
      if (state == S_XFER && tick) begin
        if (q == 2'd2) begin
          if (bit_cnt == 4'd8)        ack_smp <= sda_sync[1];
          else if (cmd_r == CMD_READ) sh      <= {sh[6:0], sda_sync[1]};
        end else if (q == 2'd3 && cmd_r == CMD_WRITE) begin
          sh <= {sh[6:0], 1'b0};
        end
      end
      if (state_nxt == S_FINISH && state != S_FINISH) begin
        rd_flag <= 1'b0;
        case (state)
          S_IDLE:  ack_err <= cmd[1];
          S_START: begin ack_err <= 1'b0; busy <= 1'b1; end
          S_STOP:  begin ack_err <= 1'b0; busy <= 1'b0; end
          default: begin
            ack_err <= (cmd_r == CMD_WRITE) && ack_smp;
            if (cmd_r == CMD_READ) begin
              rd_data <= sh;
              rd_flag <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule
